// File: rtl/shift_pkg.sv
// Shared constants, state type and op decode for the sequential shifter.
// Define SHIFT_ROTATE_EN to make op 3'b011 a rotate-right; otherwise it is reserved.
package shift_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Unsupported ops run with a zero count, so the operand passes through unchanged.
  function automatic logic op_supported(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op <= OP_ROR);
`else
    return (op <= OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step used once per cycle by shift_seq_unit.
// Rotate support is compiled in only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [2:0]  i_op,
  output logic [31:0] o_value
);

  always_comb begin
    o_value = i_value;
    case (i_op)
      OP_SLL:  o_value = {i_value[30:0], 1'b0};
      OP_SRL:  o_value = {1'b0, i_value[31:1]};
      OP_SRA:  o_value = {i_value[31], i_value[31:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  o_value = {i_value[0], i_value[31:1]};
`endif
      default: o_value = i_value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle barrel-free shifter: one bit per cycle, done pulses for one cycle.
// Optional rotate (op 3'b011) is enabled by defining SHIFT_ROTATE_EN.
// Handshake: start is accepted only in IDLE or DONE; while busy it is ignored,
// and data_out holds from the done cycle until the next accepted start.
module shift_seq_unit
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shift_op,
  input  logic [31:0] data_in,
  input  logic [31:0] shamt_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output state_t      o_dbg_state
);

  state_t               r_state;
  state_t               w_state_next;
  logic [SHAMT_W-1:0]   r_count;
  logic [2:0]           r_op;
  logic [31:0]          r_data;
  logic [31:0]          w_step;
  logic                 w_accept;
  logic                 w_unused_shamt;

  // Only the low SHAMT_W bits of the shift-amount mux are meaningful.
  assign w_unused_shamt = ^shamt_in[31:SHAMT_W];

  shift_step u_step (
    .i_value (r_data),
    .i_op    (r_op),
    .o_value (w_step)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_count == '0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_accept     = start;
        w_state_next = start ? ST_SHIFT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    busy = (r_state == ST_SHIFT);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_op    <= OP_SLL;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data  <= data_in;
        r_op    <= shift_op;
        r_count <= op_supported(shift_op) ? shamt_in[SHAMT_W-1:0] : '0;
      end else if ((r_state == ST_SHIFT) && (r_count != '0)) begin
        r_data  <= w_step;
        r_count <= r_count - SHAMT_W'(1);
      end
    end
  end

  assign data_out    = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed self-checking bench for shift_seq_unit with a cycle-level reference model.
// Compile with SHIFT_ROTATE_EN defined to exercise the rotate variant.
module tb_shift_seq_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  shift_op = 3'b000;
  logic [31:0] data_in = '0;
  logic [31:0] shamt_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  state_t      dbg_state;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  shift_seq_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .shift_op    (shift_op),
    .data_in     (data_in),
    .shamt_in    (shamt_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  function automatic bit ref_valid(input logic [2:0] op);
    return (op <= 3'd2) || (ROT && op == 3'd3);
  endfunction

  // Value after k single-bit steps, computed directly from the total shift amount.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d, input int k);
    logic signed [31:0] s;
    s = d;
    case (op)
      3'd0: return d << k;
      3'd1: return d >> k;
      3'd2: return s >>> k;
      3'd3: return (ROT && k != 0) ? ((d >> k) | (d << (32 - k))) : d;
      default: return d;
    endcase
  endfunction

  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] m_d = '0;
  logic [2:0]  m_op = '0;
  int          m_n = 0;
  int          m_k = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_data   = '0;
    end else if (!m_active && start) begin
      m_d      = data_in;
      m_op     = shift_op;
      m_n      = ref_valid(shift_op) ? int'(shamt_in[4:0]) : 0;
      m_k      = 0;
      m_active = 1'b1;
      m_done   = 1'b0;
      m_data   = data_in;
    end else if (m_active) begin
      if (m_k == m_n) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_k++;
        m_data = ref_shift(m_op, m_d, m_k);
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_active});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_data", data_out, m_data);
    end
  end

  // ---------------- driver tasks ----------------
  // Leaves the caller at the negedge right after the capture edge (latency 0).
  task automatic start_op(input logic [2:0] op, input logic [31:0] d, input logic [31:0] sh);
    @(negedge clk);
    shift_op = op; data_in = d; shamt_in = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in  = $urandom;
    shamt_in = $urandom;
    shift_op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt, output logic [31:0] res);
    lat = lat0; bcnt = 0; res = '0;
    forever begin
      if (busy) bcnt++;
      if (done) begin
        res = data_out;
        break;
      end
      if (lat >= 200) begin
        total++; bad++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_case(input string name, input logic [2:0] op, input logic [31:0] d,
                          input logic [31:0] sh, input int exp_lat, input logic [31:0] exp_res);
    int lat, bcnt;
    logic [31:0] res;
    start_op(op, d, sh);
    wait_done(0, lat, bcnt, res);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy"}, 32'(bcnt), 32'(exp_lat));
    chk({name, "_res"}, res, exp_res);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, bcnt, pulses;
    logic [31:0] res;

    chk("pin_sll", ref_shift(3'd0, 32'h0000_0001, 4), 32'h0000_0010);
    chk("pin_sra", ref_shift(3'd2, 32'h8000_0000, 31), 32'hFFFF_FFFF);
    chk("pin_srl", ref_shift(3'd1, 32'hF000_0000, 3), 32'h1E00_0000);
    chk("pin_res", ref_shift(3'd6, 32'h1234_5678, 9), 32'h1234_5678);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    reset = 1'b0;
    chk_en = 1'b1;

    run_case("sll4",  3'd0, 32'h0000_0001, 32'h0000_0004, 5,  32'h0000_0010);
    run_case("sra31", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFF);
    run_case("srl0",  3'd1, 32'hABCD_1234, 32'h0000_0000, 1,  32'hABCD_1234);
    run_case("srl3",  3'd1, 32'hF000_0000, 32'h0000_0023, 4,  32'h1E00_0000);
    run_case("sra8",  3'd2, 32'h7FFF_0000, 32'h0000_0008, 9,  32'h007F_FF00);
    run_case("rsv",   3'd5, 32'h1234_5678, 32'h0000_0007, 1,  32'h1234_5678);
`ifdef SHIFT_ROTATE_EN
    run_case("ror1",  3'd3, 32'h0000_0001, 32'h0000_0001, 2,  32'h8000_0000);
`else
    run_case("ror1",  3'd3, 32'h0000_0001, 32'h0000_0001, 1,  32'h0000_0001);
`endif

    // Start re-pulsed mid-operation must be ignored.
    start_op(3'd0, 32'h0000_0003, 32'h0000_0006);
    @(negedge clk);
    shift_op = 3'd1; data_in = 32'h0000_FFFF; shamt_in = 32'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, bcnt, res);
    chk("repulse_lat", 32'(lat), 32'd7);
    chk("repulse_res", res, 32'h0000_00C0);

    // Start held in DONE launches the next operation immediately.
    start_op(3'd0, 32'h0000_0001, 32'h0000_0002);
    wait_done(0, lat, bcnt, res);
    chk("b2b_first", res, 32'h0000_0004);
    shift_op = 3'd1; data_in = 32'h0000_0100; shamt_in = 32'h4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    chk("b2b_done", {31'b0, done}, 32'h0);
    wait_done(0, lat, bcnt, res);
    chk("b2b_lat", 32'(lat), 32'd5);
    chk("b2b_res", res, 32'h0000_0010);

    // Reset during the third SHIFT cycle aborts the operation.
    start_op(3'd0, 32'h0000_0001, 32'h0000_000A);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_data", data_out, 32'h0);
    chk("abort_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
